// File: rtl/tomasulo_reservation_station_pkg.sv
// Shared types for the Tomasulo reservation station slice.
// Defines functional-unit tags, instruction formats, the decoded operation
// record and the renamed operand register (value or producer tag).
package tomasulo_reservation_station_pkg;

    typedef enum logic [1:0] {
        ALU,
        LSU,
        BRU,
        MDU
    } e_functional_unit;

    localparam int unsigned FU_CNT = 4;

    typedef enum logic [2:0] {
        R_FORMAT,
        I_FORMAT,
        S_FORMAT,
        B_FORMAT,
        U_FORMAT,
        J_FORMAT
    } e_instruction_format;

    localparam int unsigned INSN_FMT_CNT = 6;

    typedef struct packed {
        logic [6:0]          opcode;
        e_instruction_format encoding;
        logic [4:0]          rs1;
        logic [2:0]          funct3;
        logic [4:0]          rs2;
        logic [6:0]          funct7;
        logic [4:0]          rd;
        logic [31:0]         imm;
    } operation_specification;

    // Tag view of the 64-bit operand payload; only the low bits name the producer.
    typedef struct packed {
        logic [63-$bits(e_functional_unit):0] unused;
        e_functional_unit                     fu;
    } rs_tag;

    typedef union packed {
        logic [63:0] value;
        rs_tag       rs_id;
    } register_data;

    typedef struct packed {
        logic         is_virtual;
        register_data data;
    } register;

    // A virtual operand whose producer is broadcasting right now.
    function automatic logic tag_hit(register r, logic bcast_en, e_functional_unit bcast_rs);
        return r.is_virtual && bcast_en && (r.data.rs_id.fu == bcast_rs);
    endfunction

endpackage

// File: rtl/tomasulo_reservation_station_if.sv
// Bundle of issue, broadcast, completion/retire and status signals of the
// reservation station. master: issue/rename side driving the station,
// slave: the station itself.
interface tomasulo_reservation_station_if
    import tomasulo_reservation_station_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
);
    register                 read1_value_i;
    register                 read2_value_i;
    logic                    issue_en_i;
    operation_specification  issue_op_i;
    logic                    unit_done_i;
    logic                    bcast_en_i;
    logic [DATA_WIDTH-1:0]   bcast_data_i;
    e_functional_unit        bcast_rs_i;
    logic                    retire_i;
    logic                    busy_o;
    logic                    resolved_op1_o;
    logic                    resolved_op2_o;
    logic                    retirement_ready_o;
    operation_specification  current_op_o;
    register                 op1_value_o;
    register                 op2_value_o;

    modport master (
        output read1_value_i, read2_value_i, issue_en_i, issue_op_i, unit_done_i,
               bcast_en_i, bcast_data_i, bcast_rs_i, retire_i,
        input  busy_o, resolved_op1_o, resolved_op2_o, retirement_ready_o,
               current_op_o, op1_value_o, op2_value_o
    );

    modport slave (
        input  read1_value_i, read2_value_i, issue_en_i, issue_op_i, unit_done_i,
               bcast_en_i, bcast_data_i, bcast_rs_i, retire_i,
        output busy_o, resolved_op1_o, resolved_op2_o, retirement_ready_o,
               current_op_o, op1_value_o, op2_value_o
    );
endinterface

// File: rtl/tomasulo_reservation_station_operand_slot.sv
// One source-operand slot of the reservation station.
// Ports: load_i (issue accepted) loads read_value_i with same-cycle bypass,
// clear_i (retire accepted) drops the resolved flag, active_i enables
// broadcast capture while waiting; value_o/resolved_o are registered.
module tomasulo_reservation_station_operand_slot
    import tomasulo_reservation_station_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  clear_i,
    input  logic                  active_i,
    input  register               read_value_i,
    input  logic                  bcast_en_i,
    input  logic [DATA_WIDTH-1:0] bcast_data_i,
    input  e_functional_unit      bcast_rs_i,
    output register               value_o,
    output logic                  resolved_o
);
    register value_q, value_d;
    logic    resolved_q, resolved_d;
    register bcast_value;

    always_comb begin
        bcast_value            = '0;
        bcast_value.data.value = 64'(bcast_data_i);
    end

    always_comb begin
        value_d    = value_q;
        resolved_d = resolved_q;
        if (load_i) begin
            if (tag_hit(read_value_i, bcast_en_i, bcast_rs_i)) begin
                value_d    = bcast_value;
                resolved_d = 1'b1;
            end else begin
                value_d    = read_value_i;
                resolved_d = !read_value_i.is_virtual;
            end
        end else if (clear_i) begin
            resolved_d = 1'b0;
        end else if (active_i && !resolved_q && tag_hit(value_q, bcast_en_i, bcast_rs_i)) begin
            value_d    = bcast_value;
            resolved_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q    <= '0;
            resolved_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            resolved_q <= resolved_d;
        end
    end

    assign value_o    = value_q;
    assign resolved_o = resolved_q;
endmodule

// File: rtl/tomasulo_reservation_station.sv
// Single-entry Tomasulo reservation station.
// Ports: clk, rst (sync, active-high) and the slave side of
// tomasulo_reservation_station_if (issue, CDB broadcast, unit done, retire in;
// busy/resolved/ready flags, latched op and operands out, all registered).
module tomasulo_reservation_station
    import tomasulo_reservation_station_pkg::*;
#(
    parameter int unsigned      DATA_WIDTH = 64,
    parameter e_functional_unit RS_ID      = ALU
) (
    input logic                            clk,
    input logic                            rst,
    tomasulo_reservation_station_if.slave  rs
);
    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    operation_specification op_q, op_d;
    logic                   issue_accept;
    logic                   retire_accept;
    logic                   resolved1, resolved2;

    assign issue_accept  = (state_q == StIdle) && rs.issue_en_i;
    assign retire_accept = (state_q == StDone) && rs.retire_i;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            StIdle: begin
                if (rs.issue_en_i) begin
                    state_d = StWait;
                    op_d    = rs.issue_op_i;
                end
            end
            StWait: begin
                // Uses the registered flags: a same-cycle capture does not count yet.
                if (resolved1 && resolved2 && rs.unit_done_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (rs.retire_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    tomasulo_reservation_station_operand_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot1 (
        .clk          (clk),
        .rst          (rst),
        .load_i       (issue_accept),
        .clear_i      (retire_accept),
        .active_i     (state_q == StWait),
        .read_value_i (rs.read1_value_i),
        .bcast_en_i   (rs.bcast_en_i),
        .bcast_data_i (rs.bcast_data_i),
        .bcast_rs_i   (rs.bcast_rs_i),
        .value_o      (rs.op1_value_o),
        .resolved_o   (resolved1)
    );

    tomasulo_reservation_station_operand_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot2 (
        .clk          (clk),
        .rst          (rst),
        .load_i       (issue_accept),
        .clear_i      (retire_accept),
        .active_i     (state_q == StWait),
        .read_value_i (rs.read2_value_i),
        .bcast_en_i   (rs.bcast_en_i),
        .bcast_data_i (rs.bcast_data_i),
        .bcast_rs_i   (rs.bcast_rs_i),
        .value_o      (rs.op2_value_o),
        .resolved_o   (resolved2)
    );

    assign rs.resolved_op1_o     = resolved1;
    assign rs.resolved_op2_o     = resolved2;
    assign rs.busy_o             = (state_q != StIdle);
    assign rs.retirement_ready_o = (state_q == StDone);
    assign rs.current_op_o       = op_q;
endmodule

// File: tb/tb_tomasulo_reservation_station.sv
module tb_tomasulo_reservation_station;
    import tomasulo_reservation_station_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tomasulo_reservation_station_if #(.DATA_WIDTH(64)) bus ();

    tomasulo_reservation_station #(
        .DATA_WIDTH (64),
        .RS_ID      (ALU)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rs  (bus)
    );

    typedef struct packed {
        logic                   busy;
        logic                   r1;
        logic                   r2;
        logic                   rdy;
        logic                   chk_op;
        logic                   chk_v1;
        logic                   chk_v2;
        operation_specification op;
        register                v1;
        register                v2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    operation_specification op_a, op_b, op_c;

    function automatic register imm(logic [63:0] v);
        register r;
        r            = '0;
        r.data.value = v;
        return r;
    endfunction

    function automatic register tag(e_functional_unit f);
        register r;
        r                 = '0;
        r.is_virtual      = 1'b1;
        r.data.rs_id.fu   = f;
        return r;
    endfunction

    function automatic exp_t st(logic b, logic r1, logic r2, logic rdy);
        exp_t e;
        e      = '0;
        e.busy = b;
        e.r1   = r1;
        e.r2   = r2;
        e.rdy  = rdy;
        return e;
    endfunction

    task automatic check1(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations pushed after each edge, compares mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check1("busy", 128'(bus.busy_o), 128'(e.busy));
            check1("resolved1", 128'(bus.resolved_op1_o), 128'(e.r1));
            check1("resolved2", 128'(bus.resolved_op2_o), 128'(e.r2));
            check1("ready", 128'(bus.retirement_ready_o), 128'(e.rdy));
            if (e.chk_op) check1("current_op", 128'(bus.current_op_o), 128'(e.op));
            if (e.chk_v1) check1("op1_value", 128'(bus.op1_value_o), 128'(e.v1));
            if (e.chk_v2) check1("op2_value", 128'(bus.op2_value_o), 128'(e.v2));
        end
    end

    task automatic idle_inputs();
        bus.issue_en_i  = 1'b0;
        bus.unit_done_i = 1'b0;
        bus.bcast_en_i  = 1'b0;
        bus.retire_i    = 1'b0;
    endtask

    task automatic tick(input exp_t e);
        @(posedge clk);
        #1;
        sb.push_back(e);
        idle_inputs();
    endtask

    task automatic issue(input register r1, input register r2, input operation_specification op);
        bus.issue_en_i    = 1'b1;
        bus.read1_value_i = r1;
        bus.read2_value_i = r2;
        bus.issue_op_i    = op;
    endtask

    task automatic bcast(input e_functional_unit f, input logic [63:0] d);
        bus.bcast_en_i   = 1'b1;
        bus.bcast_rs_i   = f;
        bus.bcast_data_i = d;
    endtask

    initial begin
        exp_t e;
        op_a = '{opcode: 7'h33, encoding: R_FORMAT, rs1: 5'd1, funct3: 3'd0, rs2: 5'd2,
                 funct7: 7'h00, rd: 5'd3, imm: 32'h0};
        op_b = '{opcode: 7'h13, encoding: I_FORMAT, rs1: 5'd4, funct3: 3'd7, rs2: 5'd0,
                 funct7: 7'h20, rd: 5'd9, imm: 32'h0000_0ABC};
        op_c = '{opcode: 7'h33, encoding: R_FORMAT, rs1: 5'd10, funct3: 3'd4, rs2: 5'd11,
                 funct7: 7'h01, rd: 5'd12, imm: 32'hDEAD_0000};
        idle_inputs();
        bus.read1_value_i = '0;
        bus.read2_value_i = '0;
        bus.issue_op_i    = '0;
        bus.bcast_data_i  = '0;
        bus.bcast_rs_i    = ALU;

        // Reset state
        rst = 1'b1;
        e = st(0, 0, 0, 0); e.chk_op = 1; e.chk_v1 = 1; e.chk_v2 = 1;
        tick(e);
        rst = 1'b0;

        // 1: immediate operands
        issue(imm(5), imm(7), op_a);
        e = st(1, 1, 1, 0); e.chk_op = 1; e.op = op_a;
        e.chk_v1 = 1; e.v1 = imm(5); e.chk_v2 = 1; e.v2 = imm(7);
        tick(e);
        bus.unit_done_i = 1'b1;
        tick(st(1, 1, 1, 1));
        bus.retire_i = 1'b1;
        tick(st(0, 0, 0, 0));

        // 2: tag wakeup, non-matching broadcast first
        issue(tag(ALU), imm(3), op_b);
        e = st(1, 0, 1, 0); e.chk_op = 1; e.op = op_b; e.chk_v2 = 1; e.v2 = imm(3);
        tick(e);
        bcast(LSU, 64'h55);
        tick(st(1, 0, 1, 0));
        bcast(ALU, 64'h2A);
        e = st(1, 1, 1, 0); e.chk_v1 = 1; e.v1 = imm(64'h2A);
        tick(e);
        // Resolved operand ignores later broadcasts; busy station ignores issue
        bcast(ALU, 64'h77);
        issue(imm(1), imm(2), op_a);
        e = st(1, 1, 1, 0); e.chk_v1 = 1; e.v1 = imm(64'h2A); e.chk_op = 1; e.op = op_b;
        tick(e);
        bus.unit_done_i = 1'b1;
        tick(st(1, 1, 1, 1));
        // 5: retire plus issue in the same cycle takes no new op
        bus.retire_i = 1'b1;
        issue(imm(8), imm(8), op_a);
        tick(st(0, 0, 0, 0));
        bus.retire_i = 1'b1;
        tick(st(0, 0, 0, 0));

        // 3: same-cycle bypass shared by both operands
        issue(tag(MDU), tag(MDU), op_c);
        bcast(MDU, 64'h99);
        e = st(1, 1, 1, 0); e.chk_op = 1; e.op = op_c;
        e.chk_v1 = 1; e.v1 = imm(64'h99); e.chk_v2 = 1; e.v2 = imm(64'h99);
        tick(e);
        bus.unit_done_i = 1'b1;
        tick(st(1, 1, 1, 1));
        bus.retire_i = 1'b1;
        tick(st(0, 0, 0, 0));

        // 4: premature done, retire while not ready
        issue(imm(1), tag(LSU), op_a);
        tick(st(1, 1, 0, 0));
        bus.unit_done_i = 1'b1;
        bus.retire_i    = 1'b1;
        tick(st(1, 1, 0, 0));
        // Capture and done in the same cycle: flags were not yet resolved
        bus.unit_done_i = 1'b1;
        bcast(LSU, 64'h10);
        e = st(1, 1, 1, 0); e.chk_v2 = 1; e.v2 = imm(64'h10); e.chk_v1 = 1; e.v1 = imm(1);
        tick(e);
        bus.unit_done_i = 1'b1;
        tick(st(1, 1, 1, 1));
        bus.retire_i = 1'b1;
        tick(st(0, 0, 0, 0));

        // 6: reset mid-WAIT
        issue(imm(9), tag(BRU), op_b);
        tick(st(1, 1, 0, 0));
        rst = 1'b1;
        e = st(0, 0, 0, 0); e.chk_op = 1; e.chk_v1 = 1; e.chk_v2 = 1;
        tick(e);
        rst = 1'b0;
        tick(st(0, 0, 0, 0));

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tomasulo_reservation_station.md
Name: tomasulo_reservation_station

Overview:
- Single-entry Tomasulo reservation station for one functional unit (for example the ALU).
- Accepts one issued operation with two source operands. Each operand is either an immediate value or a tag naming the producing reservation station.
- Captures tagged operands from the common-data-bus broadcast and holds the operation until the unit signals completion.
- Then holds the entry until the ROB/commit logic retires it.

Parameters:
- DATA_WIDTH, 64: width of operand values and of broadcast data.
- RS_ID, ALU (e_functional_unit): identity of this station. It does not affect matching; operands tagged with RS_ID resolve like any other tag.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- read1_value_i  in  register  operand-1 value from the register file/rename stage; is_virtual=1 means data.rs_id is the producer tag.
- read2_value_i  in  register  operand-2 value, same format as read1_value_i.
- issue_en_i  in  1  issue request. It is already qualified for this station; target decode happens upstream.
- issue_op_i  in  operation_specification  decoded operation (opcode, encoding, rs1, funct3, rs2, funct7, rd, imm).
- unit_done_i  in  1  the functional unit finished the current operation.
- bcast_en_i  in  1  broadcast valid.
- bcast_data_i  in  DATA_WIDTH  broadcast result value.
- bcast_rs_i  in  e_functional_unit  tag of the broadcasting station.
- retire_i  in  1  commit acknowledge.
- busy_o  out  1  entry occupied.
- resolved_op1_o  out  1  operand 1 holds a real value.
- resolved_op2_o  out  1  operand 2 holds a real value.
- retirement_ready_o  out  1  execution complete, awaiting retire.
- current_op_o  out  operation_specification  latched operation.
- op1_value_o  out  register  operand 1 (is_virtual=0 once resolved).
- op2_value_o  out  register  operand 2 (is_virtual=0 once resolved).

Behaviour:
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset: busy_o, resolved_op1_o, resolved_op2_o and retirement_ready_o are 0. current_op_o, op1_value_o and op2_value_o are all-zero. Reset mid-operation discards the entry.
- States:
  - IDLE: busy=0.
  - WAIT: busy=1, retirement_ready=0.
  - DONE: busy=1, retirement_ready=1.
- IDLE with issue_en_i=1 → WAIT next cycle:
  - current_op_o <= issue_op_i.
  - opN <= readN_value_i; resolved_opN <= !readN_value_i.is_virtual.
  - Same-cycle bypass: if readN is virtual, bcast_en_i=1 and readN.data.rs_id==bcast_rs_i, then opN <= {is_virtual:0, value:bcast_data_i} and resolved_opN <= 1.
- issue_en_i while busy_o=1 is ignored, including in the cycle retire_i is accepted.
- WAIT, each cycle, for each operand independently: if unresolved, bcast_en_i=1 and the operand's tag equals bcast_rs_i, capture the value, clear is_virtual and set resolved. Both operands may capture from the same broadcast. Resolved operands never change until the next issue.
- WAIT with resolved_op1_o & resolved_op2_o & unit_done_i (registered flags of the current cycle) → DONE next cycle. unit_done_i is ignored when either operand is unresolved or the station is IDLE or DONE.
- DONE with retire_i=1 → IDLE next cycle: busy and retirement_ready clear; resolved flags clear. retire_i outside DONE is ignored.
- Operand values and current_op_o are don't-care while busy_o=0, and opN_value_o is don't-care while resolved_opN=0. They must still be deterministic.

Decomposition:
- Shared package types holds:
  - e_functional_unit (includes ALU) and FU_CNT.
  - e_instruction_format (includes R_FORMAT) and INSN_FMT_CNT.
  - operation_specification struct.
  - register struct: is_virtual plus data union {value[63:0], rs_id}.
- One natural sub-module, rs_operand_slot, instantiated twice. It holds the operand register, resolved flag, issue load, bypass and broadcast capture.
- The top level holds the state FSM and current_op.

Test Plan:
1. Immediate operands: issue with both read values non-virtual, value 5 and 7 → next cycle busy=1, resolved1=resolved2=1, op1.value=5, op2.value=7. Then unit_done=1 → retirement_ready=1. Then retire=1 → busy=0.
2. Tag wakeup: issue op1 virtual rs_id=ALU, op2=3. Broadcast bcast_rs=ALU, data=0x2A two cycles later → resolved1=1 with op1.value=0x2A the cycle after. A broadcast with a non-matching tag leaves resolved1=0.
3. Same-cycle bypass and shared broadcast: issue both operands virtual with the same tag while that tag broadcasts 0x99 → both resolved with value 0x99 immediately after issue.
4. Premature done: unit_done=1 while op2 unresolved → retirement_ready stays 0. Resolve op2, then unit_done=1 → ready=1.
5. Collisions: issue_en=1 while busy → current_op unchanged. retire plus issue in the same cycle → IDLE, no new op. retire_i while not ready → no effect.
6. Reset mid-WAIT with resolved1=1 → all flags and outputs zero the next cycle.
